matrix_3row_gen: RTL and testbench
==================================

Name: matrix_3row_gen

Overview:
Upstream neighbour of the 3x3 morphological window stages (dilate/erode) in the closing pipeline. Accepts a raster pixel stream and stores two full image lines in on-chip line buffers. Emits three vertically aligned pixels per accepted input: the same column from the line two rows up, one row up, and the current row. These drive the din1/din2/din3 inputs of the window stage.

Parameters:
PIC_WIDTH, 250, pixels per line; line buffer depth.
PIC_HEIGHT, 250, lines per frame.
WIDTH, 24, pixel data width in bits.

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  reset, asynchronous, active-low
valid_in  input  1  din carries a pixel this cycle
din  input  WIDTH  input pixel, raster order
valid_out  output  1  dout1/dout2/dout3 valid this cycle
dout1  output  WIDTH  pixel from line n-2 (top row of window)
dout2  output  WIDTH  pixel from line n-1 (middle row)
dout3  output  WIDTH  pixel from line n (bottom row, current input)
frame_done  output  1  one-cycle pulse after last pixel of frame accepted

Behaviour:
- Reset (async, rst_n=0): valid_out=0, frame_done=0, dout1/2/3=0, col_cnt=0, row_cnt=0, state=FILL0. Line buffer RAM is not cleared; its contents are masked or invalid until refilled.
- Storage: two PIC_WIDTH-deep line buffers, lb0 (line n-1) and lb1 (line n-2). Both share the column pointer col_cnt (11 bits).
- On each cycle with valid_in=1:
  - read a=lb0[col_cnt] and b=lb1[col_cnt];
  - write lb0[col_cnt]<=din and lb1[col_cnt]<=a;
  - register dout3<=din, dout2<=a, dout1<=b.
- Latency: exactly 1 cycle from input acceptance to outputs. valid_out is the registered qualified valid_in.
- valid_in=0: no counter or buffer change, outputs hold. valid_out=0 the next cycle. Gaps are legal anywhere, including mid-line.
- Counters:
  - col_cnt increments per accepted pixel and wraps from PIC_WIDTH-1 to 0.
  - On that wrap, row_cnt (11 bits) increments.
  - On the wrap from PIC_HEIGHT-1 to 0, frame end is reached.
- FSM, advanced on the accepted pixel with col_cnt=PIC_WIDTH-1:
  - FILL0 (row 0) -> FILL1.
  - FILL1 (row 1) -> RUN.
  - RUN (rows 2..PIC_HEIGHT-1) stays in RUN; on the last pixel of the last row it goes to FILL0 and resets row_cnt.
- valid_out qualification: asserted only for pixels accepted in RUN, giving (PIC_HEIGHT-2)*PIC_WIDTH outputs per frame.
- frame_done: registered with the last output, so it is high in the same cycle valid_out carries pixel (PIC_HEIGHT-1, PIC_WIDTH-1).
- Back-to-back frames: the first pixel of the next frame may arrive the cycle after the last pixel. No data from the previous frame appears on a valid output.
- Reset mid-frame: the frame is aborted and the next accepted pixel is treated as (0,0).
- Window stage contract: within a line, valid_out is contiguous whenever valid_in is contiguous.

Optional Feature:
Macro MATRIX_ZERO_PAD_EN.
- Defined:
  - valid_out is asserted in all states, giving PIC_HEIGHT*PIC_WIDTH outputs per frame.
  - In FILL0, dout1=0 and dout2=0.
  - In FILL1, dout1=0.
  - This zero-fills rows above the image so output line k is centred on input line k-1. frame_done timing is unchanged.
- Undefined: behaviour exactly as above, with no padding logic synthesised.

Test Plan:
1. Reset: assert rst_n=0 mid-stream -> all outputs 0 within the same cycle, valid_out=0 until row 2 of a new frame.
2. PIC_WIDTH=4, PIC_HEIGHT=4, continuous valid_in, din=row*16+col:
   - first valid_out is 1 cycle after pixel (2,0), with dout1=0x00, dout2=0x10, dout3=0x20;
   - exactly 8 valid outputs; last is 0x13/0x23/0x33 with frame_done=1.
3. Same frame with valid_in toggling 1,0,1,0 -> identical valid output data sequence; outputs hold across gaps.
4. Two back-to-back frames, frame 2 din=0x80+row*16+col:
   - no valid_out during frame 2 rows 0-1;
   - first frame-2 output is 0x80/0x90/0xA0.
5. Reset pulse during frame row 2 col 1, then a full frame -> output identical to test 2.
6. MATRIX_ZERO_PAD_EN, test 2 stimulus:
   - 16 valid outputs;
   - first is 0/0/0x00, fifth is 0/0x00/0x10, ninth is 0x00/0x10/0x20.

Source files
------------

// File: rtl/matrix_3row_gen.sv
// Three-row vertical aligner: two line buffers turn a raster stream into
// column triples (n-2, n-1, n). Define MATRIX_ZERO_PAD_EN to emit zero-padded rows for the first two lines.
module matrix_3row_gen #(
    parameter int PIC_WIDTH  = 250,
    parameter int PIC_HEIGHT = 250,
    parameter int WIDTH      = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] din,
    output logic             valid_out,
    output logic [WIDTH-1:0] dout1,
    output logic [WIDTH-1:0] dout2,
    output logic [WIDTH-1:0] dout3,
    output logic             frame_done
);

    localparam int          AW       = (PIC_WIDTH > 1) ? $clog2(PIC_WIDTH) : 1;
    localparam logic [10:0] COL_LAST = 11'(PIC_WIDTH - 1);
    localparam logic [10:0] ROW_LAST = 11'(PIC_HEIGHT - 1);

    localparam logic [1:0] ST_FILL0 = 2'd0;
    localparam logic [1:0] ST_FILL1 = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    logic [WIDTH-1:0] lb0_mem [PIC_WIDTH];
    logic [WIDTH-1:0] lb1_mem [PIC_WIDTH];

    logic [10:0]      col_cnt_q, col_cnt_d;
    logic [10:0]      row_cnt_q, row_cnt_d;
    logic [1:0]       state_q, state_d;
    logic             valid_out_q, valid_out_d;
    logic             frame_done_q, frame_done_d;
    logic [WIDTH-1:0] dout1_q, dout1_d;
    logic [WIDTH-1:0] dout2_q, dout2_d;
    logic [WIDTH-1:0] dout3_q, dout3_d;

    logic [AW-1:0]    addr_s;
    logic [WIDTH-1:0] a_s;
    logic [WIDTH-1:0] b_s;
    logic             col_last_s;
    logic             row_last_s;

    assign addr_s     = col_cnt_q[AW-1:0];
    assign a_s        = lb0_mem[addr_s];
    assign b_s        = lb1_mem[addr_s];
    assign col_last_s = (col_cnt_q == COL_LAST);
    assign row_last_s = (row_cnt_q == ROW_LAST);

    // Next-state: counters, fill/run sequencing and output capture per accepted pixel
    always_comb begin
        col_cnt_d    = col_cnt_q;
        row_cnt_d    = row_cnt_q;
        state_d      = state_q;
        valid_out_d  = 1'b0;
        frame_done_d = 1'b0;
        dout1_d      = dout1_q;
        dout2_d      = dout2_q;
        dout3_d      = dout3_q;

        if (valid_in) begin
            if (col_last_s) begin
                col_cnt_d = 11'd0;
                if (row_last_s) begin
                    row_cnt_d = 11'd0;
                end else begin
                    row_cnt_d = row_cnt_q + 11'd1;
                end
            end else begin
                col_cnt_d = col_cnt_q + 11'd1;
            end

            case (state_q)
                ST_FILL0: state_d = col_last_s ? ST_FILL1 : ST_FILL0;
                ST_FILL1: state_d = col_last_s ? ST_RUN : ST_FILL1;
                ST_RUN:   state_d = (col_last_s && row_last_s) ? ST_FILL0 : ST_RUN;
                default:  state_d = ST_FILL0;
            endcase

            dout3_d      = din;
            dout2_d      = a_s;
            dout1_d      = b_s;
            frame_done_d = (state_q == ST_RUN) && col_last_s && row_last_s;
`ifdef MATRIX_ZERO_PAD_EN
            // Rows above the image read as zero so every input line yields an output line
            valid_out_d = 1'b1;
            if (state_q == ST_FILL0) begin
                dout1_d = {WIDTH{1'b0}};
                dout2_d = {WIDTH{1'b0}};
            end else if (state_q == ST_FILL1) begin
                dout1_d = {WIDTH{1'b0}};
            end else begin
                dout1_d = b_s;
            end
`else
            valid_out_d = (state_q == ST_RUN);
`endif
        end else begin
            valid_out_d = 1'b0;
        end
    end

    // Control and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt_q    <= 11'd0;
            row_cnt_q    <= 11'd0;
            state_q      <= ST_FILL0;
            valid_out_q  <= 1'b0;
            frame_done_q <= 1'b0;
            dout1_q      <= {WIDTH{1'b0}};
            dout2_q      <= {WIDTH{1'b0}};
            dout3_q      <= {WIDTH{1'b0}};
        end else begin
            col_cnt_q    <= col_cnt_d;
            row_cnt_q    <= row_cnt_d;
            state_q      <= state_d;
            valid_out_q  <= valid_out_d;
            frame_done_q <= frame_done_d;
            dout1_q      <= dout1_d;
            dout2_q      <= dout2_d;
            dout3_q      <= dout3_d;
        end
    end

    // Line buffers are left uninitialised; stale lines are masked by the fill states
    always_ff @(posedge clk) begin
        if (valid_in) begin
            lb0_mem[addr_s] <= din;
            lb1_mem[addr_s] <= a_s;
        end
    end

    assign valid_out  = valid_out_q;
    assign frame_done = frame_done_q;
    assign dout1      = dout1_q;
    assign dout2      = dout2_q;
    assign dout3      = dout3_q;

endmodule

// File: tb/tb_matrix_3row_gen.sv
// Scoreboard bench for matrix_3row_gen on a 4x4 image; the reference keeps
// the whole current frame as an array and looks two rows up by index.
module tb_matrix_3row_gen;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int DW = 24;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          valid_in = 1'b0;
    logic [DW-1:0] din      = '0;
    logic          valid_out;
    logic [DW-1:0] dout1, dout2, dout3;
    logic          frame_done;

    matrix_3row_gen #(
        .PIC_WIDTH (W),
        .PIC_HEIGHT(H),
        .WIDTH     (DW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .din       (din),
        .valid_out (valid_out),
        .dout1     (dout1),
        .dout2     (dout2),
        .dout3     (dout3),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
        logic [DW-1:0] d3;
        logic          fd;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    logic [DW-1:0] img [H][W];
    int            mr = 0, mc = 0;
    int            checks = 0, failures = 0;
    int            pushed = 0, seen = 0;

    logic          prev_vin = 1'b0;
    logic          hold_ok  = 1'b0;
    logic [DW-1:0] h1 = '0, h2 = '0, h3 = '0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Reference: pixel (r,c) pairs with the same column of rows r-2 and r-1
    task automatic model_accept(input logic [DW-1:0] d);
        exp_t e;
        img[mr][mc] = d;
        e.d3 = d;
        e.fd = (mr == H - 1) && (mc == W - 1);
        e.d1 = '0;
        e.d2 = '0;
        if (mr >= 2) e.d1 = img[mr-2][mc];
        if (mr >= 1) e.d2 = img[mr-1][mc];
`ifdef MATRIX_ZERO_PAD_EN
        exp_q.push_back(e);
        pushed++;
`else
        if (mr >= 2) begin
            exp_q.push_back(e);
            pushed++;
        end
`endif
        mc++;
        if (mc == W) begin
            mc = 0;
            mr++;
            if (mr == H) mr = 0;
        end
    endtask

    task automatic put_pixel(input logic [DW-1:0] d);
        valid_in = 1'b1;
        din      = d;
        model_accept(d);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    task automatic idle(input int n);
        valid_in = 1'b0;
        din      = DW'($urandom);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst_n    = 1'b0;
        valid_in = 1'b0;
        pushed   = pushed - exp_q.size();
        exp_q.delete();
        mr = 0;
        mc = 0;
        repeat (n) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // mode 0: continuous, 1: alternate gaps, 2: random gaps; base<0 gives random data
    task automatic run_frame(input int base, input int mode, input int npix);
        logic [DW-1:0] d;
        for (int p = 0; p < npix; p++) begin
            if (base < 0) d = DW'($urandom);
            else          d = DW'(base + (p / W) * 16 + (p % W));
            put_pixel(d);
            if (mode == 1) idle(1);
            else if (mode == 2 && $urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
    endtask

    // Monitor: pop on every valid output, check reset values and hold across gaps
    always @(negedge clk) begin
        if (!rst_n) begin
            chk1("rst_valid_out", valid_out, 1'b0);
            chk1("rst_frame_done", frame_done, 1'b0);
            chk("rst_dout1", dout1, '0);
            chk("rst_dout2", dout2, '0);
            chk("rst_dout3", dout3, '0);
            hold_ok  = 1'b1;
            h1 = '0;
            h2 = '0;
            h3 = '0;
            prev_vin = 1'b0;
        end else begin
            if (valid_out === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_valid: got valid_out=1 with dout %h/%h/%h expected no output",
                             dout1, dout2, dout3);
                    hold_ok = 1'b0;
                end else begin
                    mon_e = exp_q.pop_front();
                    seen++;
                    chk("dout1", dout1, mon_e.d1);
                    chk("dout2", dout2, mon_e.d2);
                    chk("dout3", dout3, mon_e.d3);
                    chk1("frame_done", frame_done, mon_e.fd);
                    h1 = mon_e.d1;
                    h2 = mon_e.d2;
                    h3 = mon_e.d3;
                    hold_ok = 1'b1;
                end
            end else begin
                chk1("idle_frame_done", frame_done, 1'b0);
                if (!prev_vin && hold_ok) begin
                    chk("hold_dout1", dout1, h1);
                    chk("hold_dout2", dout2, h2);
                    chk("hold_dout3", dout3, h3);
                end
                if (prev_vin) hold_ok = 1'b0;
            end
            prev_vin = valid_in;
        end
    end

    initial begin
        @(posedge clk);
        #1;
        do_reset(3);
        run_frame(0, 0, W * H);
        run_frame(0, 1, W * H);
        run_frame(0, 0, W * H);
        run_frame(128, 0, W * H);
        run_frame(0, 0, 2 * W + 1);
        do_reset(2);
        run_frame(0, 0, W * H);
        run_frame(0, 0, W + 2);
        idle(2);
        do_reset(1);
        for (int f = 0; f < 4; f++) run_frame(-1, 2, W * H);
        run_frame(0, 0, W * H);
        idle(5);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d outputs pending expected 0", exp_q.size());
        end
        checks++;
        if (seen != pushed) begin
            failures++;
            $display("FAIL output_count: got %0d valid outputs expected %0d", seen, pushed);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
